// File: rtl/multi_ranger_pkg.sv
// ----------------------------------------------------------------------------
// ranger_pkg
// Shared definitions for the multi-channel ultrasonic ranger:
//   - FSM state codes (kept as plain localparam constants so the encoding is
//     stable and visible in waveforms of older tools)
//   - default cycle constants for a 100 MHz system clock
// No ports; imported by multi_ranger and prox_encode.
// ----------------------------------------------------------------------------
package ranger_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_TRIG      = 3'd1;
    localparam state_t ST_WAIT_RISE = 3'd2;
    localparam state_t ST_MEASURE   = 3'd3;
    localparam state_t ST_REPORT    = 3'd4;
    localparam state_t ST_GAP       = 3'd5;

    // Defaults for HC-SR04-style sensors at 100 MHz.
    localparam int DEF_N_CH         = 2;
    localparam int DEF_TRIG_CYC     = 1000;      // 10 us trigger pulse
    localparam int DEF_RISE_TO_CYC  = 100000;    // 1 ms for the echo to start
    localparam int DEF_ECHO_MAX_CYC = 4000000;   // 40 ms longest echo
    localparam int DEF_GAP_CYC      = 6000000;   // 60 ms between slots
    localparam int DEF_BASE_CYC     = 6029;      // first proximity threshold
    localparam int DEF_LEVELS       = 8;
    localparam int DEF_CNT_W        = 23;

endpackage

// File: rtl/multi_ranger_prox_encode.sv
// ----------------------------------------------------------------------------
// prox_encode
// Combinational thermometer encoder for one echo measurement.
//   cycles_i  [CNT_W-1:0]  measured echo width in clock cycles
//   timeout_i              measurement ended by timeout (forces all ones)
//   therm_o   [LEVELS-1:0] thermometer: bit 0 always set, bit j (j>=1) set
//                          when cycles_i > BASE_CYC << (j-1)
// A shorter echo means a closer object, but the thermometer counts "distance
// bands passed": more bits set = farther away or no echo at all.
// ----------------------------------------------------------------------------
module prox_encode
    import ranger_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LEVELS   = DEF_LEVELS,
    parameter int BASE_CYC = DEF_BASE_CYC
)
(
    input  logic [CNT_W-1:0]  cycles_i,
    input  logic              timeout_i,
    output logic [LEVELS-1:0] therm_o
);

    // Thresholds grow to BASE_CYC << (LEVELS-2); widening the compare by
    // LEVELS bits keeps every shifted threshold representable.
    localparam int WIDE = CNT_W + LEVELS;

    logic [WIDE-1:0] cycles_wide;

    assign cycles_wide = {{LEVELS{1'b0}}, cycles_i};
    assign therm_o[0]  = 1'b1;

    genvar gi;
    generate
        for (gi = 1; gi < LEVELS; gi++) begin : g_lvl
            localparam logic [WIDE-1:0] THR = WIDE'(BASE_CYC) << (gi - 1);
            assign therm_o[gi] = timeout_i || (cycles_wide > THR);
        end
    endgenerate

endmodule

// File: rtl/multi_ranger.sv
// ----------------------------------------------------------------------------
// multi_ranger
// Round-robin controller for N_CH ultrasonic rangers. Each slot fires one
// trigger pulse, times the echo of that channel, reports it and updates the
// channel's proximity thermometer, then idles GAP_CYC cycles.
// Ports:
//   clk, rst_n           100 MHz clock, asynchronous active-low reset
//   enable               keep sequencing; when low, finish slot and park
//   echo [N_CH-1:0]      raw asynchronous echo lines
//   trigger [N_CH-1:0]   trigger pulses (one-hot or zero)
//   meas_valid           one-cycle strobe when a slot completes
//   meas_ch [2:0]        channel of the completed slot
//   meas_cycles          echo width in cycles (saturated, 0 on rise timeout)
//   meas_timeout         slot ended by timeout
//   prox [N_CH*LEVELS-1:0] per-channel thermometers, channel c at c*LEVELS
// ----------------------------------------------------------------------------
module multi_ranger
    import ranger_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int TRIG_CYC     = DEF_TRIG_CYC,
    parameter int RISE_TO_CYC  = DEF_RISE_TO_CYC,
    parameter int ECHO_MAX_CYC = DEF_ECHO_MAX_CYC,
    parameter int GAP_CYC      = DEF_GAP_CYC,
    parameter int BASE_CYC     = DEF_BASE_CYC,
    parameter int LEVELS       = DEF_LEVELS,
    parameter int CNT_W        = DEF_CNT_W
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [N_CH-1:0]          echo,
    output logic [N_CH-1:0]          trigger,
    output logic                     meas_valid,
    output logic [2:0]               meas_ch,
    output logic [CNT_W-1:0]         meas_cycles,
    output logic                     meas_timeout,
    output logic [N_CH*LEVELS-1:0]   prox
);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYC - 1);
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TO_CYC - 1);
    localparam logic [CNT_W-1:0] ECHO_MAX  = CNT_W'(ECHO_MAX_CYC);
    localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_MAX_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       CH_LAST   = 3'(N_CH - 1);

    // ------------------------------------------------------------------
    // Echo synchronisers (all channels, so a channel switch sees settled data)
    // ------------------------------------------------------------------
    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= echo;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ch_q, ch_d;
    logic             armed_q, armed_d;
    logic             timeout_d;
    logic             echo_act;
    logic             rise;
    logic             report_load;
    logic [N_CH-1:0]  trigger_q, trigger_d;

    // Only the active channel's synchronised echo matters.
    always_comb begin
        echo_act = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_q == 3'(i)) begin
                echo_act = sync2_q[i];
            end
        end
    end

    // armed_q records that echo was seen low while in WAIT_RISE, so an echo
    // still high from a previous (timed-out) slot cannot count as a rise.
    assign rise = armed_q && echo_act;

    always_comb begin
        armed_d = 1'b0;
        if (state_q == ST_WAIT_RISE && state_d == ST_WAIT_RISE) begin
            armed_d = armed_q || !echo_act;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_TRIG;
                    cnt_d   = '0;
                end
            end
            ST_TRIG: begin
                if (cnt_q >= TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_RISE: begin
                // A rise on the last allowed cycle still wins over timeout.
                if (rise) begin
                    state_d = ST_MEASURE;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q >= RISE_LAST) begin
                    state_d   = ST_REPORT;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_MEASURE: begin
                if (!echo_act) begin
                    state_d = ST_REPORT;
                end else if (cnt_q >= ECHO_LAST) begin
                    // Give up without waiting for the echo to fall.
                    state_d   = ST_REPORT;
                    cnt_d     = ECHO_MAX;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REPORT: begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
            ST_GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    cnt_d   = '0;
                    ch_d    = (ch_q >= CH_LAST) ? 3'd0 : ch_q + 3'd1;
                    state_d = enable ? ST_TRIG : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Result registers are loaded on the edge that enters REPORT, so the
    // strobe is visible during the REPORT cycle: two synchroniser cycles plus
    // one FSM cycle after the raw echo falls.
    assign report_load = (state_d == ST_REPORT);

    always_comb begin
        trigger_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            trigger_d[i] = (state_d == ST_TRIG) && (ch_d == 3'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= 3'd0;
            armed_q   <= 1'b0;
            trigger_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            armed_q   <= armed_d;
            trigger_q <= trigger_d;
        end
    end

    assign trigger = trigger_q;

    // ------------------------------------------------------------------
    // Measurement report
    // ------------------------------------------------------------------
    logic             meas_valid_q;
    logic [2:0]       meas_ch_q;
    logic [CNT_W-1:0] meas_cycles_q;
    logic             meas_timeout_q;
    logic [LEVELS-1:0] enc_therm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_valid_q   <= 1'b0;
            meas_ch_q      <= 3'd0;
            meas_cycles_q  <= '0;
            meas_timeout_q <= 1'b0;
        end else begin
            meas_valid_q <= report_load;
            if (report_load) begin
                meas_ch_q      <= ch_q;
                meas_cycles_q  <= cnt_d;
                meas_timeout_q <= timeout_d;
            end
        end
    end

    assign meas_valid   = meas_valid_q;
    assign meas_ch      = meas_ch_q;
    assign meas_cycles  = meas_cycles_q;
    assign meas_timeout = meas_timeout_q;

    // Encode the value being loaded so prox and meas_* update together.
    prox_encode #(
        .CNT_W    (CNT_W),
        .LEVELS   (LEVELS),
        .BASE_CYC (BASE_CYC)
    ) u_prox_encode (
        .cycles_i  (cnt_d),
        .timeout_i (timeout_d),
        .therm_o   (enc_therm)
    );

    // One holding register per channel; each keeps its value until that
    // channel reports again.
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_prox
            logic [LEVELS-1:0] lvl_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lvl_q <= '0;
                end else if (report_load && ch_q == 3'(gi)) begin
                    lvl_q <= enc_therm;
                end
            end

            assign prox[gi*LEVELS +: LEVELS] = lvl_q;
        end
    endgenerate

endmodule

// File: tb/tb_multi_ranger.sv
// ----------------------------------------------------------------------------
// tb_multi_ranger
// Drives sensor echoes for the ranger and compares every report against a
// behavioural model: expected width is the width the bench itself drove, and
// the thermometer comes from a doubling-threshold loop. The echo-max limit is
// shortened so the bench stays short; the encoder's large thresholds are
// exercised on a standalone prox_encode instance.
// ----------------------------------------------------------------------------
module tb_multi_ranger;

    localparam int N_CH         = 2;
    localparam int TRIG_CYC     = 1000;
    localparam int RISE_TO_CYC  = 2000;
    localparam int ECHO_MAX_CYC = 16000;
    localparam int GAP_CYC      = 100;
    localparam int BASE_CYC     = 6029;
    localparam int LEVELS       = 8;
    localparam int CNT_W        = 23;

    logic                   clk;
    logic                   rst_n;
    logic                   enable;
    logic [N_CH-1:0]        echo;
    logic [N_CH-1:0]        trigger;
    logic                   meas_valid;
    logic [2:0]             meas_ch;
    logic [CNT_W-1:0]       meas_cycles;
    logic                   meas_timeout;
    logic [N_CH*LEVELS-1:0] prox;

    logic [CNT_W-1:0]       enc_cycles;
    logic                   enc_timeout;
    logic [LEVELS-1:0]      enc_therm;

    int n_total = 0;
    int n_bad   = 0;

    logic [LEVELS-1:0] pm [N_CH];
    int exp_ch;

    multi_ranger #(
        .N_CH         (N_CH),
        .TRIG_CYC     (TRIG_CYC),
        .RISE_TO_CYC  (RISE_TO_CYC),
        .ECHO_MAX_CYC (ECHO_MAX_CYC),
        .GAP_CYC      (GAP_CYC),
        .BASE_CYC     (BASE_CYC),
        .LEVELS       (LEVELS),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .echo         (echo),
        .trigger      (trigger),
        .meas_valid   (meas_valid),
        .meas_ch      (meas_ch),
        .meas_cycles  (meas_cycles),
        .meas_timeout (meas_timeout),
        .prox         (prox)
    );

    prox_encode #(
        .CNT_W    (CNT_W),
        .LEVELS   (LEVELS),
        .BASE_CYC (BASE_CYC)
    ) u_enc (
        .cycles_i  (enc_cycles),
        .timeout_i (enc_timeout),
        .therm_o   (enc_therm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Number of bands passed: start at one, add one per doubling threshold
    // the width exceeds, cap at LEVELS.
    function automatic logic [LEVELS-1:0] ref_therm(input longint unsigned d, input bit to);
        logic [LEVELS-1:0] r;
        longint unsigned thr;
        int n;
        r   = '0;
        thr = longint'(BASE_CYC);
        n   = 1;
        if (to) n = LEVELS;
        while (n < LEVELS && d > thr) begin
            n++;
            thr = thr * 2;
        end
        for (int i = 0; i < n; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [N_CH*LEVELS-1:0] pack_model();
        logic [N_CH*LEVELS-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c*LEVELS +: LEVELS] = pm[c];
        return v;
    endfunction

    // mode 0: pulse of 'width' after 'dly'; 1: no echo; 2: raise and hold;
    // 3: echo already high -> drop after 'dly', rise 200 later, pulse 'width'
    task automatic run_slot(input int mode, input int dly, input int width, input bit drop_en);
        int ch;
        int hi;
        int lat;
        bit ok;
        longint unsigned exp_cyc;
        bit exp_to;
        ch = exp_ch;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (trigger != '0) begin
                ok = 1'b1;
                break;
            end
        end
        check("trig_start", 64'(ok), 64'd1);
        if (!ok) return;
        check("trig_onehot", 64'(trigger), 64'd1 << ch);
        hi = 0;
        while (trigger[ch] && hi < 5000) begin
            hi++;
            @(negedge clk);
        end
        check("trig_width", 64'(hi), 64'(TRIG_CYC));

        ok      = 1'b0;
        lat     = 0;
        exp_cyc = 0;
        exp_to  = 1'b0;
        case (mode)
            1: begin
                for (int k = 1; k <= RISE_TO_CYC + 50; k++) begin
                    @(negedge clk);
                    if (meas_valid) begin
                        lat = k;
                        ok  = 1'b1;
                        break;
                    end
                end
                check("rise_to_delay_ok", 64'(lat == RISE_TO_CYC || lat == RISE_TO_CYC + 1), 64'd1);
                exp_to = 1'b1;
            end
            2: begin
                repeat (dly) @(negedge clk);
                echo[ch] = 1'b1;
                for (int k = 1; k <= ECHO_MAX_CYC + 100; k++) begin
                    @(negedge clk);
                    if (meas_valid) begin
                        ok = 1'b1;
                        break;
                    end
                end
                check("echo_max_report", 64'(ok), 64'd1);
                exp_cyc = longint'(ECHO_MAX_CYC);
                exp_to  = 1'b1;
            end
            default: begin
                if (mode == 3) begin
                    repeat (dly) @(negedge clk);
                    echo[ch] = 1'b0;
                    repeat (200) @(negedge clk);
                end else begin
                    repeat (dly) @(negedge clk);
                end
                echo[ch] = 1'b1;
                for (int i = 0; i < width; i++) begin
                    if (drop_en && i == width / 2) enable = 1'b0;
                    @(negedge clk);
                end
                echo[ch] = 1'b0;
                for (int k = 1; k <= 10; k++) begin
                    @(negedge clk);
                    if (meas_valid) begin
                        lat = k;
                        ok  = 1'b1;
                        break;
                    end
                end
                check("valid_latency", 64'(lat), 64'd3);
                exp_cyc = longint'(width);
            end
        endcase

        pm[ch] = ref_therm(exp_cyc, exp_to);
        check("meas_ch", 64'(meas_ch), 64'(ch));
        check("meas_cycles", 64'(meas_cycles), 64'(exp_cyc));
        check("meas_timeout", 64'(meas_timeout), 64'(exp_to));
        check("prox", 64'(prox), 64'(pack_model()));
        $display("slot ch=%0d mode=%0d cycles=%0d timeout=%0b prox=0x%h", ch, mode,
                 meas_cycles, meas_timeout, prox);
        @(negedge clk);
        check("valid_one_cycle", 64'(meas_valid), 64'd0);
        exp_ch = (ch + 1) % N_CH;
    endtask

    initial begin
        longint unsigned vals [10];
        bit seen;
        rst_n       = 1'b0;
        enable      = 1'b0;
        echo        = '0;
        enc_cycles  = '0;
        enc_timeout = 1'b0;
        exp_ch      = 0;
        for (int c = 0; c < N_CH; c++) pm[c] = '0;

        // Standalone encoder: threshold edges, large widths and random values.
        vals = '{0, 1, 6029, 6030, 12058, 12059, 50000, 385856, 385857, 8388607};
        foreach (vals[i]) begin
            enc_cycles  = CNT_W'(vals[i]);
            enc_timeout = 1'b0;
            #1;
            check("enc_edge", 64'(enc_therm), 64'(ref_therm(vals[i], 1'b0)));
            $display("enc cycles=%0d therm=0x%h", vals[i], enc_therm);
        end
        for (int i = 0; i < 40; i++) begin
            enc_cycles  = CNT_W'($urandom_range(0, 400000));
            enc_timeout = 1'($urandom_range(0, 3) == 0);
            #1;
            check("enc_rand", 64'(enc_therm), 64'(ref_therm(longint'(enc_cycles), enc_timeout)));
        end

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_trigger", 64'(trigger), 64'd0);
        check("rst_valid", 64'(meas_valid), 64'd0);
        check("rst_ch", 64'(meas_ch), 64'd0);
        check("rst_cycles", 64'(meas_cycles), 64'd0);
        check("rst_timeout", 64'(meas_timeout), 64'd0);
        check("rst_prox", 64'(prox), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;

        run_slot(0, 500, 5000, 1'b0);     // ch0 -> 0x01
        run_slot(0, 300, 12500, 1'b0);    // ch1 -> 0x07, ch0 kept
        run_slot(0, 100, 6029, 1'b0);     // ch0 boundary -> 0x01
        run_slot(0, 100, 6030, 1'b0);     // ch1 boundary -> 0x03
        run_slot(1, 0, 0, 1'b0);          // ch0 rise timeout -> 0xFF
        run_slot(2, 300, 0, 1'b0);        // ch1 echo-max, echo left high
        run_slot(0, 400, 3000, 1'b0);     // ch0 while ch1 echo still high
        run_slot(3, 300, 2500, 1'b0);     // ch1 stale echo then real pulse
        for (int i = 0; i < 3; i++) begin
            run_slot(0, int'($urandom_range(0, 1500)), int'($urandom_range(1, 7000)), 1'b0);
        end

        // Enable drops during MEASURE: slot completes, then no more triggers.
        run_slot(0, 200, 4000, 1'b1);
        seen = 1'b0;
        repeat (2000) begin
            @(negedge clk);
            if (trigger != '0) seen = 1'b1;
        end
        check("parked_no_trigger", 64'(seen), 64'd0);
        enable = 1'b1;
        run_slot(0, 250, 1200, 1'b0);

        // Reset in the middle of a trigger pulse.
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (trigger != '0) begin
                seen = 1'b1;
                break;
            end
        end
        check("pre_reset_trigger", 64'(seen), 64'd1);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_trigger", 64'(trigger), 64'd0);
        check("async_rst_prox", 64'(prox), 64'd0);
        check("async_rst_valid", 64'(meas_valid), 64'd0);
        for (int c = 0; c < N_CH; c++) pm[c] = '0;
        exp_ch = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_slot(0, 100, 800, 1'b0);      // restarts on ch0

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
